// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes that take a zero-extended immediate, fixed register indices and widths.
package cpu_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

   // Logical immediates are unsigned; everything else sign-extends.
   function automatic logic imm_is_zero_ext(input logic [5:0] opcode);
      return (opcode == OP_SLTIU) || (opcode == OP_ANDI) ||
             (opcode == OP_ORI)   || (opcode == OP_XORI);
   endfunction

endpackage

// File: rtl/instr_decode_if.sv
// Decode-stage bus: instruction and write-back inputs in, operands/immediate/debug data out.
// Jal and link_addr exist only when JAL_LINK_EN is defined.
interface instr_decode_if;
   import cpu_pkg::*;

   logic [DATA_W-1:0] Instruction;
   logic              RegWrite;
   logic              RegDst;
   logic              MemtoReg;
`ifdef JAL_LINK_EN
   logic              Jal;
   logic [DATA_W-1:0] link_addr;
`endif
   logic [DATA_W-1:0] ALU_result;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] read_data_1;
   logic [DATA_W-1:0] read_data_2;
   logic [DATA_W-1:0] imm_extended;
   logic [REG_AW-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;

   // No handshake: every input is sampled each cycle and outputs are combinational.
   modport master (
      output Instruction, RegWrite, RegDst, MemtoReg,
`ifdef JAL_LINK_EN
      output Jal, link_addr,
`endif
      output ALU_result, mem_data, dbg_addr,
      input  read_data_1, read_data_2, imm_extended, dbg_data
   );

   modport slave (
      input  Instruction, RegWrite, RegDst, MemtoReg,
`ifdef JAL_LINK_EN
      input  Jal, link_addr,
`endif
      input  ALU_result, mem_data, dbg_addr,
      output read_data_1, read_data_2, imm_extended, dbg_data
   );

endinterface

// File: rtl/reg_file_32x32.sv
// 32x32 register file: async active-low clear, two read ports plus a debug port, one write port.
module reg_file_32x32
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_1,
   input  logic [REG_AW-1:0] raddr_2,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] rdata_1,
   output logic [DATA_W-1:0] rdata_2,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs_q [32];
   logic [DATA_W-1:0] regs_d [32];

   // Entry 0 is never written, so it holds its reset value of zero forever.
   always_comb begin
      for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
      if (we && (waddr != REG_ZERO)) regs_d[waddr] = wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
      end
   end

   // Reads see the pre-edge contents; no write bypass.
   always_comb begin
      rdata_1  = (raddr_1  == REG_ZERO) ? '0 : regs_q[raddr_1];
      rdata_2  = (raddr_2  == REG_ZERO) ? '0 : regs_q[raddr_2];
      dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs_q[dbg_addr];
   end

endmodule

// File: rtl/instr_decode.sv
// Decode/register-file stage: field slicing, write-back muxing and immediate extension.
// Optional JAL_LINK_EN adds the jal link write of link_addr into register 31.
module instr_decode
   import cpu_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   instr_decode_if.slave  bus
);

   logic [5:0]        opcode;
   logic [REG_AW-1:0] rs;
   logic [REG_AW-1:0] rt;
   logic [REG_AW-1:0] rd;
   logic [15:0]       imm;
   logic              wr_en;
   logic [REG_AW-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   always_comb begin
      opcode = bus.Instruction[31:26];
      rs     = bus.Instruction[25:21];
      rt     = bus.Instruction[20:16];
      rd     = bus.Instruction[15:11];
      imm    = bus.Instruction[15:0];
   end

   // Jal outranks the controller's selects for both destination and data.
   always_comb begin
      wr_en   = bus.RegWrite;
      wr_addr = bus.RegDst ? rd : rt;
      wr_data = bus.MemtoReg ? bus.mem_data : bus.ALU_result;
`ifdef JAL_LINK_EN
      if (bus.Jal) begin
         wr_en   = 1'b1;
         wr_addr = REG_RA;
         wr_data = bus.link_addr;
      end
`endif
   end

   always_comb begin
      if (imm_is_zero_ext(opcode)) bus.imm_extended = {16'h0000, imm};
      else                         bus.imm_extended = {{16{imm[15]}}, imm};
   end

   reg_file_32x32 u_reg_file (
      .clk      (clk),
      .reset    (reset),
      .we       (wr_en),
      .waddr    (wr_addr),
      .wdata    (wr_data),
      .raddr_1  (rs),
      .raddr_2  (rt),
      .dbg_addr (bus.dbg_addr),
      .rdata_1  (bus.read_data_1),
      .rdata_2  (bus.read_data_2),
      .dbg_data (bus.dbg_data)
   );

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed scenarios plus random cycles against an array-based register model.
module tb_instr_decode;

   logic clk;
   logic reset;

   instr_decode_if bus ();

   instr_decode dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef JAL_LINK_EN
   localparam bit HAS_JAL = 1'b1;
`else
   localparam bit HAS_JAL = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] model [32];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_imm(input logic [31:0] instr);
      int op;
      int imm;
      op  = int'(instr[31:26]);
      imm = int'(instr[15:0]);
      if (op >= 11 && op <= 14) return imm;
      if (imm >= 32768) return imm - 65536;
      return imm;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   // One instruction: drive at negedge, check reads against the model, then retire at posedge.
   task automatic do_cycle(input logic [31:0] instr, input logic rw, input logic rd_sel,
                           input logic m2r, input logic jal, input logic [31:0] link,
                           input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] dbg);
      int dest;
      logic [31:0] data;
      logic do_jal;
      do_jal = HAS_JAL && jal;
      @(negedge clk);
      bus.Instruction = instr;
      bus.RegWrite    = rw;
      bus.RegDst      = rd_sel;
      bus.MemtoReg    = m2r;
`ifdef JAL_LINK_EN
      bus.Jal         = jal;
      bus.link_addr   = link;
`endif
      bus.ALU_result  = alu;
      bus.mem_data    = mem;
      bus.dbg_addr    = dbg;
      #1;
      check("rd1", bus.read_data_1, model[instr[25:21]]);
      check("rd2", bus.read_data_2, model[instr[20:16]]);
      check("imm", bus.imm_extended, ref_imm(instr));
      check("dbg", bus.dbg_data, model[dbg]);
      @(posedge clk);
      if (do_jal) begin
         dest = 31;
         data = link;
      end else begin
         dest = rd_sel ? int'(instr[15:11]) : int'(instr[20:16]);
         data = m2r ? mem : alu;
      end
      if ((rw || do_jal) && dest != 0) model[dest] = data;
   endtask

   task automatic check_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
      @(negedge clk);
      bus.RegWrite = 1'b0;
`ifdef JAL_LINK_EN
      bus.Jal      = 1'b0;
`endif
      bus.dbg_addr = r;
      #1;
      check(tag, bus.dbg_data, exp);
   endtask

   initial begin
      bus.Instruction = '0;
      bus.RegWrite    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.MemtoReg    = 1'b0;
`ifdef JAL_LINK_EN
      bus.Jal         = 1'b0;
      bus.link_addr   = '0;
`endif
      bus.ALU_result  = '0;
      bus.mem_data    = '0;
      bus.dbg_addr    = '0;
      model_clear();

      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 32; i++) check_reg("reset_sweep", 5'(i), 32'h0);

      // rd=5 write via RegDst; rs=5 reads old zero during the cycle, new value after.
      do_cycle({6'h00, 5'd5, 5'd0, 5'd5, 11'h0}, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,
               32'h1234_5678, 32'h0, 5'd5);
      #1;
      check("rs5_after_write", bus.read_data_1, 32'h1234_5678);

      // rt=0 destination is discarded; rt=9 takes mem_data.
      do_cycle({6'h23, 5'd1, 5'd0, 16'h0}, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,
               32'h0, 32'hFFFF_FFFF, 5'd0);
      check_reg("reg0_stays_zero", 5'd0, 32'h0);
      do_cycle({6'h23, 5'd1, 5'd9, 16'h0}, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,
               32'h0, 32'hFFFF_FFFF, 5'd9);
      check_reg("reg9_mem", 5'd9, 32'hFFFF_FFFF);

      do_cycle({6'h08, 10'h0, 16'h8001}, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      #1;
      check("imm_addi_sext", bus.imm_extended, 32'hFFFF_8001);
      do_cycle({6'h0D, 10'h0, 16'h8001}, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      #1;
      check("imm_ori_zext", bus.imm_extended, 32'h0000_8001);

`ifdef JAL_LINK_EN
      do_cycle({6'h00, 5'd0, 5'd0, 5'd12, 11'h0}, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,
               32'h0000_00C0, 32'h0, 5'd12);
      do_cycle({6'h03, 5'd0, 5'd0, 5'd12, 11'h0}, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0044,
               32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd31);
      check_reg("jal_reg31", 5'd31, 32'h0000_0044);
      check_reg("jal_rd_unchanged", 5'd12, 32'h0000_00C0);
`endif

      // Asynchronous clear mid-cycle, no clock edge involved.
      do_cycle({6'h00, 5'd7, 5'd0, 5'd7, 11'h0}, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,
               32'hA5A5_A5A5, 32'h0, 5'd7);
      check_reg("reg7_written", 5'd7, 32'hA5A5_A5A5);
      bus.Instruction = {6'h0C, 5'd7, 5'd7, 16'hF00F};
      #1;
      reset = 1'b0;
      #1;
      check("reg7_async_clear", bus.dbg_data, 32'h0);
      check("rd1_in_reset", bus.read_data_1, 32'h0);
      check("imm_in_reset", bus.imm_extended, 32'h0000_F00F);
      #1;
      reset = 1'b1;
      model_clear();

      for (int n = 0; n < 300; n++) begin
         logic [31:0] instr;
         instr = $urandom;
         if ($urandom_range(0, 3) == 0) instr[31:26] = 6'($urandom_range(11, 14));
         do_cycle(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
      end
      for (int i = 0; i < 32; i++) check_reg("final_sweep", 5'(i), model[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
